apb_master_arb: RTL

Two-port APB4 master with round-robin arbitration for the UART's `apb_if` bus. It accepts single-transfer commands from two internal requesters, serialises them, and drives the APB SETUP/ACCESS protocol. It absorbs slave wait states, bounds them with a timeout, and returns read data or an error to the requester that issued the command. It sits between the host-side command sources and the `apb_if` signals feeding the UART register slave.

---
 rtl/apb_master_arb.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/apb_master_arb.sv
// Two-requester APB4 master: round-robin arbitration, SETUP/ACCESS sequencing,
// wait-state timeout, and per-port one-cycle response pulses.
module apb_master_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        preset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [11:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_strb,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [11:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_strb,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [11:0] paddr,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [7:0] LP_WAIT_MAX = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_last_grant;
    logic        r_grant;
    logic [7:0]  r_wait_cnt;
    logic        r_psel, r_penable, r_pwrite;
    logic [11:0] r_paddr;
    logic [31:0] r_pwdata;
    logic [3:0]  r_pstrb;
    logic        r_rsp0_valid, r_rsp0_err, r_rsp1_valid, r_rsp1_err;
    logic [31:0] r_rsp0_rdata, r_rsp1_rdata;

    logic        w_accept;
    logic        w_grant_idx;
    logic        w_sel_write;
    logic [11:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_strb;
    logic        w_done;
    logic        w_rsp_err;
    logic [31:0] w_rsp_rdata;

    // Ready is gated by reset so nothing is accepted while preset_n is low.
    assign w_accept    = preset_n && (r_state == ST_IDLE) && (req0_valid || req1_valid);
    assign w_grant_idx = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign req0_ready  = w_accept && !w_grant_idx;
    assign req1_ready  = w_accept &&  w_grant_idx;

    assign w_sel_write = w_grant_idx ? req1_write : req0_write;
    assign w_sel_addr  = w_grant_idx ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_grant_idx ? req1_wdata : req0_wdata;
    assign w_sel_strb  = w_grant_idx ? req1_strb  : req0_strb;

    // A transfer ends on pready or when the final permitted wait cycle also stalls.
    assign w_done      = pready || (r_wait_cnt == LP_WAIT_MAX);
    assign w_rsp_err   = pready ? pslverr : 1'b1;
    assign w_rsp_rdata = (pready && !r_pwrite) ? prdata : 32'd0;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!preset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_wait_cnt   <= 8'd0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= 12'd0;
            r_pwdata     <= 32'd0;
            r_pstrb      <= 4'd0;
            r_rsp0_valid <= 1'b0;
            r_rsp0_err   <= 1'b0;
            r_rsp0_rdata <= 32'd0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_err   <= 1'b0;
            r_rsp1_rdata <= 32'd0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_grant      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_pwrite     <= w_sel_write;
                        r_paddr      <= w_sel_addr;
                        r_pwdata     <= w_sel_write ? w_sel_wdata : 32'd0;
                        r_pstrb      <= w_sel_write ? w_sel_strb  : 4'd0;
                        r_psel       <= 1'b1;
                        r_wait_cnt   <= 8'd0;
                        r_state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= 8'd0;
                    r_state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= ST_IDLE;
                        if (r_grant) begin
                            r_rsp1_valid <= 1'b1;
                            r_rsp1_err   <= w_rsp_err;
                            r_rsp1_rdata <= w_rsp_rdata;
                        end else begin
                            r_rsp0_valid <= 1'b1;
                            r_rsp0_err   <= w_rsp_err;
                            r_rsp0_rdata <= w_rsp_rdata;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign psel       = r_psel;
    assign penable    = r_penable;
    assign pwrite     = r_pwrite;
    assign paddr      = r_paddr;
    assign pwdata     = r_pwdata;
    assign pstrb      = r_pstrb;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_err   = r_rsp0_err;
    assign rsp0_rdata = r_rsp0_rdata;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_err   = r_rsp1_err;
    assign rsp1_rdata = r_rsp1_rdata;

endmodule
